// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock, start/busy/done handshake.
// Define MUL_SIGNED_EN to add the sgn port and a FIX state for two's-complement operands.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MUL_SIGNED_EN
  input  logic                 sgn,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
`ifdef MUL_SIGNED_EN
  localparam logic [1:0] FIX  = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   load_a;
  logic [WIDTH-1:0]   load_b;
  logic               accept;
`ifdef MUL_SIGNED_EN
  logic               neg_flag;
  logic               load_neg;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] fixed;
`endif

  // acc never exceeds WIDTH bits after a shift, so the add below cannot overflow WIDTH+1 bits.
  always_comb begin
    busy   = (state != IDLE) && (state != DONE);
    accept = start && !busy;
    sum    = acc + (mplier[0] ? {1'b0, mcand} : '0);
`ifdef MUL_SIGNED_EN
    // The most-negative operand negates to itself, which reads as 2^(WIDTH-1) unsigned.
    load_a   = (sgn && a[WIDTH-1]) ? -a : a;
    load_b   = (sgn && b[WIDTH-1]) ? -b : b;
    load_neg = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
    prod     = {acc[WIDTH-1:0], mplier};
    fixed    = neg_flag ? -prod : prod;
`else
    load_a = a;
    load_b = b;
`endif
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath is a handful of flops, not a memory, so it is all cleared on reset.
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      o      <= '0;
      done   <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          acc    <= {1'b0, sum[WIDTH:1]};
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef MUL_SIGNED_EN
            state <= FIX;
`else
            state <= DONE;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        FIX: begin
          acc    <= {1'b0, fixed[2*WIDTH-1:WIDTH]};
          mplier <= fixed[WIDTH-1:0];
          state  <= DONE;
        end
`endif
        DONE: begin
          o     <= {acc[WIDTH-1:0], mplier};
          done  <= 1'b1;
          state <= start ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        mcand  <= load_a;
        mplier <= load_b;
        acc    <= '0;
        cnt    <= '0;
`ifdef MUL_SIGNED_EN
        neg_flag <= load_neg;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=16 (honours MUL_SIGNED_EN if defined).
module tb_seq_multiplier;

  localparam int W = 16;
`ifdef MUL_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
`ifdef MUL_SIGNED_EN
  logic           sgn;
`endif
  logic           busy;
  logic           done;
  logic [2*W-1:0] o;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef MUL_SIGNED_EN
    .sgn   (sgn),
`endif
    .busy  (busy),
    .done  (done),
    .o     (o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge that samples start (edge 0).
  task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Returns the edge count to the done pulse (-1 on timeout) and how many samples saw busy.
  task automatic wait_done(output int k, output int busy_n);
    busy_n = busy ? 1 : 0;
    k = 0;
    while (k < 60) begin
      step();
      k++;
      if (busy) busy_n++;
      if (done) break;
    end
    if (!done) k = -1;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp);
    int k, bn;
    do_start(x, y);
    wait_done(k, bn);
    check({tag, "_lat"}, 64'(k), 64'(LAT));
    check({tag, "_o"}, 64'(o), 64'(exp));
  endtask

  initial begin
    int k, bn, d0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef MUL_SIGNED_EN
    sgn = 1'b0;
`endif
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_o", 64'(o), 64'd0);
    rst = 1'b0;
    step();

    // Basic product with handshake timing.
    d0 = done_cnt;
    do_start(16'd20, 16'd29);
    wait_done(k, bn);
    check("basic_lat", 64'(k), 64'(LAT));
    check("basic_o", 64'(o), 64'd580);
    check("basic_busy_cycles", 64'(bn), 64'(LAT - 1));
    step();
    check("basic_done_pulse", 64'(done), 64'd0);
    check("basic_done_count", 64'(done_cnt - d0), 64'd1);

    run_op("basic2", 16'd210, 16'd2239, 32'd470190);
    run_op("zero", 16'd0, 16'd0, 32'd0);
    run_op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    run_op("small", 16'd8, 16'd2, 32'd16);

    // Back-to-back: second start lands in the DONE cycle of the first.
    do_start(16'd200, 16'd29);
    repeat (LAT - 1) step();
    a = 16'd2;
    b = 16'd29;
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_first_done", 64'(done), 64'd1);
    check("b2b_first_o", 64'(o), 64'd5800);
    wait_done(k, bn);
    check("b2b_second_lat", 64'(k), 64'(LAT));
    check("b2b_second_o", 64'(o), 64'd58);
    step();

    // Start while busy is ignored.
    d0 = done_cnt;
    do_start(16'd20, 16'd29);
    repeat (4) step();
    a = 16'd5;
    b = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(k, bn);
    check("ign_lat", 64'(k), 64'(LAT - 5));
    check("ign_o", 64'(o), 64'd580);
    repeat (LAT + 2) step();
    check("ign_done_count", 64'(done_cnt - d0), 64'd1);

    // Reset in flight aborts silently and clears o.
    d0 = done_cnt;
    do_start(16'd20, 16'd29);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_o", 64'(o), 64'd0);
    repeat (LAT + 2) step();
    check("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
    run_op("after_rst", 16'd20, 16'd29, 32'd580);

`ifdef MUL_SIGNED_EN
    sgn = 1'b1;
    run_op("sgn_neg3x5", 16'hFFFD, 16'd5, 32'hFFFF_FFF1);
    run_op("sgn_minmin", 16'h8000, 16'h8000, 32'h4000_0000);
    run_op("sgn_neg3xneg3", 16'hFFFD, 16'hFFFD, 32'd9);
    sgn = 1'b0;
    run_op("uns_fffdx5", 16'hFFFD, 16'd5, 32'h0004_FFF1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
